// File: rtl/ib_prefetch_seq_if.sv
// ib_prefetch_seq_if: longword fetch handshake between the prefetcher (master) and memory (slave).
interface ib_prefetch_seq_if;
    logic        mem_req_h;
    logic [29:0] mem_addr_h;
    logic        mem_ack_h;
    logic [31:0] mem_data_h;
    modport master (output mem_req_h, mem_addr_h, input mem_ack_h, mem_data_h);
    modport slave  (input mem_req_h, mem_addr_h, output mem_ack_h, mem_data_h);
endinterface

// File: rtl/ib_prefetch_seq.sv
// ib_prefetch_seq: 8-byte instruction prefetch buffer with longword fetch FSM and decoder byte/word takes.
module ib_prefetch_seq (
    input  logic              mclk_l,
    input  logic              reset_l,
    input  logic              flush_h,
    input  logic [31:0]       vaddr_h,
    ib_prefetch_seq_if.master mem,
    input  logic [1:0]        dec_req_h,
    output logic [15:0]       xbuf_h,
    output logic              ld_ir_l,
    output logic              ld_osr_l,
    output logic [3:0]        ib_cnt_h,
    output logic              stall_h,
    output logic [31:0]       pc_h
);
    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;
    state_t      state_q, state_d;
    logic [63:0] buf_q, buf_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] pc_q, pc_d;
    logic [29:0] faddr_q, faddr_d, maddr_q, maddr_d;
    logic        first_q, first_d, req_q;
    logic [1:0]  off_q, off_d;
    logic [3:0]  take_sz, take, rem, fill;
    logic        accept, ack_ok;
    logic [31:0] fill_word;
    always_comb begin
        take_sz   = dec_req_h == 2'b11 ? 4'd2 : {3'b0, |dec_req_h};
        accept    = |dec_req_h && !flush_h && cnt_q >= take_sz;
        take      = accept ? take_sz : 4'd0;
        rem       = cnt_q - take;
        ack_ok    = state_q == REQ && mem.mem_ack_h && !flush_h;
        // the first longword after a flush starts at the flush target's byte offset
        fill      = first_q ? 4'd4 - {2'b0, off_q} : 4'd4;
        fill_word = first_q ? mem.mem_data_h >> {off_q, 3'b0} : mem.mem_data_h;
        cnt_d     = flush_h ? 4'd0 : rem + (ack_ok ? fill : 4'd0);
        buf_d     = flush_h ? 64'b0 : (buf_q >> {take, 3'b0}) | (ack_ok ? {32'b0, fill_word} << {rem, 3'b0} : 64'b0);
        pc_d      = flush_h ? vaddr_h : pc_q + {28'b0, take};
        faddr_d   = flush_h ? vaddr_h[31:2] : faddr_q + {29'b0, ack_ok};
        first_d   = flush_h | (first_q & !ack_ok);
        off_d     = flush_h ? vaddr_h[1:0] : off_q;
        state_d   = flush_h ? ((state_q != IDLE && !mem.mem_ack_h) ? DROP : IDLE)
                  : state_q == DROP ? (mem.mem_ack_h ? IDLE : DROP)
                  : (state_q == REQ && !mem.mem_ack_h) ? REQ
                  : cnt_d <= 4'd4 ? REQ : IDLE;
        // the outstanding address is latched only when a new request is issued
        maddr_d   = state_d == REQ ? faddr_d : maddr_q;
    end
    always_ff @(posedge mclk_l or negedge reset_l) begin
        if (!reset_l) begin
            state_q <= IDLE;
            buf_q   <= '0;
            cnt_q   <= '0;
            pc_q    <= '0;
            faddr_q <= '0;
            maddr_q <= '0;
            first_q <= 1'b0;
            off_q   <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            faddr_q <= faddr_d;
            maddr_q <= maddr_d;
            first_q <= first_d;
            off_q   <= off_d;
            req_q   <= state_d != IDLE;
        end
    end
    assign mem.mem_req_h  = req_q;
    assign mem.mem_addr_h = maddr_q;
    assign xbuf_h         = buf_q[15:0];
    assign ib_cnt_h       = cnt_q;
    assign pc_h           = pc_q;
    assign stall_h        = |dec_req_h && !accept;
    assign ld_ir_l        = !(accept && dec_req_h == 2'b01);
    assign ld_osr_l       = !(accept && dec_req_h[1]);
endmodule

// File: tb/tb_ib_prefetch_seq.sv
// tb_ib_prefetch_seq: directed scenarios checked against a byte-queue model every cycle plus literal expectations.
module tb_ib_prefetch_seq;
    logic        mclk_l = 1'b0;
    logic        reset_l = 1'b0;
    logic        flush_h = 1'b0;
    logic [31:0] vaddr_h = '0;
    logic [1:0]  dec_req_h = '0;
    logic [15:0] xbuf_h;
    logic        ld_ir_l, ld_osr_l, stall_h;
    logic [3:0]  ib_cnt_h;
    logic [31:0] pc_h;
    int          checks = 0, errors = 0;
    bit          chk_en = 1'b0;
    ib_prefetch_seq_if mif();
    ib_prefetch_seq dut (
        .mclk_l(mclk_l), .reset_l(reset_l), .flush_h(flush_h), .vaddr_h(vaddr_h), .mem(mif),
        .dec_req_h(dec_req_h), .xbuf_h(xbuf_h), .ld_ir_l(ld_ir_l), .ld_osr_l(ld_osr_l),
        .ib_cnt_h(ib_cnt_h), .stall_h(stall_h), .pc_h(pc_h)
    );
    always #5 mclk_l = ~mclk_l;
    // model: byte queue, pc, next fetch longword, outstanding request and whether its data is to be dropped
    byte unsigned q[$];
    bit          busy = 1'b0, drop = 1'b0, first = 1'b0;
    logic [31:0] m_pc = '0;
    logic [29:0] m_faddr = '0, m_maddr = '0;
    logic [1:0]  m_off = '0;
    function automatic int tsz(logic [1:0] d);
        return d == 2'b11 ? 2 : (d != 2'b00 ? 1 : 0);
    endfunction
    function automatic bit m_acc();
        return dec_req_h != 2'b00 && !flush_h && q.size() >= tsz(dec_req_h);
    endfunction
    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, got, exp, $time);
        end
    endtask
    always @(posedge mclk_l or negedge reset_l) begin
        if (!reset_l) begin
            q.delete(); busy = 0; drop = 0; first = 0; m_pc = '0; m_faddr = '0; m_maddr = '0; m_off = '0;
        end else if (flush_h) begin
            q.delete(); m_pc = vaddr_h; m_faddr = vaddr_h[31:2]; m_off = vaddr_h[1:0]; first = 1;
            if (busy && !mif.mem_ack_h) drop = 1;
            else begin busy = 0; drop = 0; end
        end else begin
            if (m_acc()) begin
                for (int i = 0; i < tsz(dec_req_h); i++) void'(q.pop_front());
                m_pc = m_pc + 32'(tsz(dec_req_h));
            end
            if (busy && mif.mem_ack_h) begin
                if (drop) begin busy = 0; drop = 0; end
                else begin
                    for (int b = (first ? int'(m_off) : 0); b < 4; b++) q.push_back(mif.mem_data_h[8*b +: 8]);
                    m_faddr = m_faddr + 30'd1; first = 0;
                    busy = q.size() <= 4;
                    if (busy) m_maddr = m_faddr;
                end
            end else if (!busy && q.size() <= 4) begin
                busy = 1; m_maddr = m_faddr;
            end
        end
    end
    always @(negedge mclk_l) begin
        if (chk_en) begin
            chk("cyc_req", {31'b0, mif.mem_req_h}, {31'b0, busy});
            chk("cyc_addr", {2'b0, mif.mem_addr_h}, {2'b0, m_maddr});
            chk("cyc_cnt", {28'b0, ib_cnt_h}, 32'(q.size()));
            chk("cyc_xbuf", {16'b0, xbuf_h}, {16'b0, (q.size() > 1 ? q[1] : 8'h00), (q.size() > 0 ? q[0] : 8'h00)});
            chk("cyc_pc", pc_h, m_pc);
            chk("cyc_stall", {31'b0, stall_h}, {31'b0, dec_req_h != 2'b00 && !m_acc()});
            chk("cyc_ld_ir", {31'b0, ld_ir_l}, {31'b0, !(m_acc() && dec_req_h == 2'b01)});
            chk("cyc_ld_osr", {31'b0, ld_osr_l}, {31'b0, !(m_acc() && dec_req_h[1])});
        end
    end
    task automatic go(int n);
        repeat (n) @(posedge mclk_l);
        #1;
    endtask
    initial begin
        mif.mem_ack_h = 1'b0; mif.mem_data_h = '0;
        go(2);
        dec_req_h = 2'b01; #1;
        chk("rst_req", {31'b0, mif.mem_req_h}, 0); chk("rst_cnt", {28'b0, ib_cnt_h}, 0);
        chk("rst_stall", {31'b0, stall_h}, 1); chk("rst_ld_ir", {31'b0, ld_ir_l}, 1);
        chk_en = 1'b1;
        reset_l = 1'b1; flush_h = 1'b1; vaddr_h = 32'h0000_1002; dec_req_h = 2'b00;
        go(1); flush_h = 1'b0;
        go(1); #5;
        chk("fill_req", {31'b0, mif.mem_req_h}, 1); chk("fill_addr", {2'b0, mif.mem_addr_h}, 32'h400);
        mif.mem_ack_h = 1'b1; mif.mem_data_h = 32'hDDCC_BBAA;
        go(1); mif.mem_ack_h = 1'b0; #5;
        chk("align_cnt", {28'b0, ib_cnt_h}, 2); chk("align_xbuf", {16'b0, xbuf_h}, 32'hDDCC);
        chk("align_pc", pc_h, 32'h1002); chk("align_next", {2'b0, mif.mem_addr_h}, 32'h401);
        dec_req_h = 2'b01;
        go(1); dec_req_h = 2'b11; #5;
        chk("word_stall", {31'b0, stall_h}, 1); chk("word_osr_hold", {31'b0, ld_osr_l}, 1);
        chk("word_cnt1", {28'b0, ib_cnt_h}, 1);
        go(1); mif.mem_ack_h = 1'b1; mif.mem_data_h = 32'h4433_2211; #5;
        chk("word_cnt_stay", {28'b0, ib_cnt_h}, 1);
        go(1); mif.mem_ack_h = 1'b0; #5;
        chk("word_cnt5", {28'b0, ib_cnt_h}, 5); chk("word_osr", {31'b0, ld_osr_l}, 0);
        chk("word_xbuf", {16'b0, xbuf_h}, 32'h11DD);
        go(1); dec_req_h = 2'b00; #5;
        chk("word_osr_one", {31'b0, ld_osr_l}, 1); chk("word_cnt3", {28'b0, ib_cnt_h}, 3);
        chk("word_pc", pc_h, 32'h1005); chk("word_addr", {2'b0, mif.mem_addr_h}, 32'h402);
        mif.mem_ack_h = 1'b1; mif.mem_data_h = 32'h8877_6655;
        go(1); mif.mem_ack_h = 1'b0; dec_req_h = 2'b11;
        go(1); dec_req_h = 2'b01;
        go(1); mif.mem_ack_h = 1'b1; mif.mem_data_h = 32'hCCBB_AA99; #5;
        chk("both_ir", {31'b0, ld_ir_l}, 0); chk("both_cnt4", {28'b0, ib_cnt_h}, 4);
        go(1); mif.mem_ack_h = 1'b0; dec_req_h = 2'b00; #5;
        chk("both_cnt7", {28'b0, ib_cnt_h}, 7); chk("both_pc", pc_h, 32'h1009);
        chk("both_xbuf", {16'b0, xbuf_h}, 32'h7766);
        dec_req_h = 2'b11;
        go(2); dec_req_h = 2'b00; flush_h = 1'b1; vaddr_h = 32'h0000_2000;
        go(1); flush_h = 1'b0; #5;
        chk("drop_req", {31'b0, mif.mem_req_h}, 1); chk("drop_addr", {2'b0, mif.mem_addr_h}, 32'h404);
        chk("drop_pc", pc_h, 32'h2000);
        go(2); mif.mem_ack_h = 1'b1; mif.mem_data_h = 32'hFFFF_FFFF;
        go(1); mif.mem_ack_h = 1'b0; #5;
        chk("drop_idle", {31'b0, mif.mem_req_h}, 0); chk("drop_cnt", {28'b0, ib_cnt_h}, 0);
        go(1); #5;
        chk("drop_new", {2'b0, mif.mem_addr_h}, 32'h800);
        flush_h = 1'b1; vaddr_h = 32'hFFFF_FFFC; mif.mem_ack_h = 1'b1; mif.mem_data_h = 32'h1234_5678;
        go(1); flush_h = 1'b0; mif.mem_ack_h = 1'b0; #5;
        chk("fack_req", {31'b0, mif.mem_req_h}, 0); chk("fack_cnt", {28'b0, ib_cnt_h}, 0);
        go(1); #5;
        chk("wrap_top", {2'b0, mif.mem_addr_h}, 32'h3FFF_FFFF);
        mif.mem_ack_h = 1'b1; mif.mem_data_h = 32'h0403_0201;
        go(1); mif.mem_ack_h = 1'b0; #5;
        chk("wrap_zero", {2'b0, mif.mem_addr_h}, 0); chk("wrap_cnt", {28'b0, ib_cnt_h}, 4);
        chk("wrap_xbuf", {16'b0, xbuf_h}, 32'h0201);
        dec_req_h = 2'b11;
        go(2); dec_req_h = 2'b01; #5;
        chk("pc_wrap", pc_h, 0); chk("empty_stall", {31'b0, stall_h}, 1);
        mif.mem_ack_h = 1'b1; mif.mem_data_h = 32'h0A0B_0C0D; dec_req_h = 2'b00;
        go(1); mif.mem_ack_h = 1'b0; #5;
        chk("pre_rst_addr", {2'b0, mif.mem_addr_h}, 1);
        reset_l = 1'b0; dec_req_h = 2'b01; #1;
        chk("arst_req", {31'b0, mif.mem_req_h}, 0); chk("arst_addr", {2'b0, mif.mem_addr_h}, 0);
        chk("arst_cnt", {28'b0, ib_cnt_h}, 0); chk("arst_xbuf", {16'b0, xbuf_h}, 0);
        chk("arst_stall", {31'b0, stall_h}, 1); chk("arst_ld_ir", {31'b0, ld_ir_l}, 1);
        mif.mem_ack_h = 1'b1;
        go(2); reset_l = 1'b1;
        go(1); mif.mem_ack_h = 1'b0; #5;
        chk("post_rst_cnt", {28'b0, ib_cnt_h}, 0); chk("post_rst_req", {31'b0, mif.mem_req_h}, 1);
        go(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
